// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type, accumulator width rule and start-time config check
// for the streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_state_e;

    function automatic int acc_bits(input int bits, input int channels, input int k);
        return 2 * bits + $clog2(channels * k * k);
    endfunction

    function automatic logic cfg_ok(input logic [13:0] n, input logic [5:0] s, input int k, input int max_n);
        return (int'(n) >= k) && (int'(n) <= max_n) && (s != '0) && (int'(s) < int'(n));
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one channel's K-1 row delay lines (addressed by the current column)
// feeding a KxK window shift register; everything advances only on an accepted beat.
module conv_line_buffer #(
    parameter int MaxMatrixSize = 28,
    parameter int KernelSize    = 3,
    parameter int Bits          = 8,
    parameter int AddrBits      = $clog2(MaxMatrixSize)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   en_i,
    input  logic [AddrBits-1:0]                    col_i,
    input  logic [Bits-1:0]                        pix_i,
    output logic [KernelSize*KernelSize*Bits-1:0]  win_o
);

    localparam int K = KernelSize;

    logic [Bits-1:0] lb_q  [K-1][MaxMatrixSize];
    logic [Bits-1:0] win_q [K][K];
    logic [Bits-1:0] tap   [K];

    // tap[0] is the oldest row in the window, tap[K-1] the incoming pixel
    always_comb begin
        for (int r = 0; r < K - 1; r++) tap[r] = lb_q[K-2-r][col_i];
        tap[K-1] = pix_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lb_q  <= '{default: '0};
            win_q <= '{default: '0};
        end else if (en_i) begin
            for (int j = 0; j < K - 1; j++) lb_q[j][col_i] <= tap[K-1-j];
            for (int y = 0; y < K; y++) begin
                for (int x = 0; x < K - 1; x++) win_q[y][x] <= win_q[y][x+1];
                win_q[y][K-1] <= tap[y];
            end
        end
    end

    always_comb begin
        win_o = '0;
        for (int y = 0; y < K; y++)
            for (int x = 0; x < K; x++)
                win_o[(y*K+x)*Bits +: Bits] = win_q[y][x];
    end

endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: multi-channel strided KxK streaming convolution with valid/ready and start/done.
// Define CONV_RELU_EN to clamp negative results to zero in the final pipeline stage.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int MaxMatrixSize = 28,
    parameter int KernelSize    = 3,
    parameter int Bits          = 8,
    parameter int Channels      = 2,
    localparam int AccBits      = acc_bits(Bits, Channels, KernelSize)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          start_i,
    input  logic [13:0]                                   matrix_size_i,
    input  logic [5:0]                                    stride_i,
    input  logic [Channels*KernelSize*KernelSize*Bits-1:0] weights_i,
    input  logic [Channels*Bits-1:0]                      data_i,
    input  logic                                          data_valid_i,
    output logic                                          data_ready_o,
    output logic signed [AccBits-1:0]                     conv_o,
    output logic                                          conv_valid_o,
    input  logic                                          conv_ready_i,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          cfg_err_o
);

    localparam int K  = KernelSize;
    localparam int KK = K * K;
    localparam int AW = $clog2(MaxMatrixSize);
    localparam int PW = 2 * Bits;

    conv_state_e state_q, state_d;
    logic [13:0] n_q, col_q, row_q;
    logic [5:0]  s_q, cph_q, rph_q;
    logic        cfg_err_q;
    logic [3:0]  v_q;
    logic        stall, accept, last_pix, win_ok, start_ok;
    logic [KK*Bits-1:0]        win    [Channels];
    logic signed [PW-1:0]      prod_d [Channels][KK];
    logic signed [PW-1:0]      prod_q [Channels][KK];
    logic signed [AccBits-1:0] csum_d [Channels];
    logic signed [AccBits-1:0] csum_q [Channels];
    logic signed [AccBits-1:0] total, post, conv_q;

    assign stall        = v_q[3] && !conv_ready_i;
    assign data_ready_o = (state_q == RUN) && !stall;
    assign accept       = data_ready_o && data_valid_i;
    assign last_pix     = (col_q == n_q - 14'd1) && (row_q == n_q - 14'd1);
    assign win_ok       = (row_q >= 14'(K-1)) && (col_q >= 14'(K-1)) && (rph_q == '0) && (cph_q == '0);
    assign start_ok     = cfg_ok(matrix_size_i, stride_i, K, MaxMatrixSize);

    assign conv_o       = conv_q;
    assign conv_valid_o = v_q[3];
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign cfg_err_o    = cfg_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && start_ok) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (v_q[2:0] == '0 && !stall) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // stride phases restart on every row so gating needs no divider
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            n_q       <= '0;
            s_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            cph_q     <= '0;
            rph_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                cfg_err_q <= !start_ok;
                n_q       <= matrix_size_i;
                s_q       <= stride_i;
                col_q     <= '0;
                row_q     <= '0;
                cph_q     <= '0;
                rph_q     <= '0;
            end else if (accept) begin
                if (col_q == n_q - 14'd1) begin
                    col_q <= '0;
                    cph_q <= '0;
                    row_q <= row_q + 14'd1;
                    rph_q <= (row_q < 14'(K-1) || rph_q == s_q - 6'd1) ? '0 : rph_q + 6'd1;
                end else begin
                    col_q <= col_q + 14'd1;
                    cph_q <= (col_q < 14'(K-1) || cph_q == s_q - 6'd1) ? '0 : cph_q + 6'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < Channels; g++) begin : g_ch
        conv_line_buffer #(
            .MaxMatrixSize(MaxMatrixSize),
            .KernelSize   (KernelSize),
            .Bits         (Bits),
            .AddrBits     (AW)
        ) u_lb (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .en_i (accept),
            .col_i(col_q[AW-1:0]),
            .pix_i(data_i[g*Bits +: Bits]),
            .win_o(win[g])
        );
    end

    always_comb begin
        for (int c = 0; c < Channels; c++)
            for (int i = 0; i < KK; i++)
                prod_d[c][i] = PW'($signed(win[c][i*Bits +: Bits])) * PW'($signed(weights_i[(c*KK+i)*Bits +: Bits]));
    end

    always_comb begin
        for (int c = 0; c < Channels; c++) begin
            csum_d[c] = '0;
            for (int i = 0; i < KK; i++) csum_d[c] = csum_d[c] + AccBits'(prod_q[c][i]);
        end
        total = '0;
        for (int c = 0; c < Channels; c++) total = total + csum_q[c];
    end

`ifdef CONV_RELU_EN
    assign post = total[AccBits-1] ? '0 : total;
`else
    assign post = total;
`endif

    // a stalled output freezes the whole pipeline, so no window is lost or repeated
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q    <= '0;
            prod_q <= '{default: '0};
            csum_q <= '{default: '0};
            conv_q <= '0;
        end else if (!stall) begin
            v_q    <= {v_q[2:0], accept && win_ok};
            prod_q <= prod_d;
            csum_q <= csum_d;
            conv_q <= post;
        end
    end

endmodule
